// File: rtl/act_arbiter_if.sv
// rtl/act_arbiter_if.sv - requester, activation-unit and response signals of act_arbiter
// master is the arbiter's view; slave is the view of the surrounding requesters and activation unit.
interface act_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          act_valid_in;
  logic [DATA_WIDTH-1:0]         act_data_in;
  logic                          act_valid_out;
  logic [DATA_WIDTH-1:0]         act_data_out;
  logic                          rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, act_valid_out, act_data_out,
    output req_ready, act_valid_in, act_data_in, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    output req_valid, req_data, act_valid_out, act_data_out,
    input  req_ready, act_valid_in, act_data_in, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/act_arbiter.sv
// rtl/act_arbiter.sv - round-robin burst arbiter sharing one activation unit among NUM_REQ streams
// Optional per-requester beat counters on stat_beats when ACT_ARB_STATS_EN is defined.
module act_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REQ     = 4,
  parameter int BURST_LEN   = 8,
  parameter int ACT_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef ACT_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0] stat_beats,
`endif
  act_arbiter_if.master        bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy_r;
  logic [ID_W-1:0]  id_sr [ACT_LATENCY];

  logic             xfer;
  logic             last_beat;
  logic             found;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  next_ptr;

  // First requester with valid high, scanning from ptr and wrapping.
  always_comb begin : rr_pick
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign xfer      = (state == SERVE) && bus.req_valid[grant];
  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign next_ptr  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (state == SERVE) bus.req_ready[grant] = 1'b1;
  end

  assign bus.act_valid_in = xfer;
  assign bus.act_data_in  = xfer ? bus.req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.rsp_valid    = bus.act_valid_out;
  assign bus.rsp_data     = bus.act_data_out;
  assign bus.rsp_id       = id_sr[ACT_LATENCY-1];
  assign bus.busy         = busy_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= pick;
            beat_cnt <= '0;
            state    <= SERVE;
            busy_r   <= 1'b1;
          end
        end
        SERVE: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          // A dropped valid ends the burst early; otherwise leave after the last beat.
          if (!bus.req_valid[grant] || last_beat) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            ptr    <= next_ptr;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Grant of each beat travels alongside the activation unit so rsp_id lines up with rsp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ACT_LATENCY; i++) id_sr[i] <= '0;
    end else begin
      id_sr[0] <= xfer ? grant : '0;
      for (int i = 1; i < ACT_LATENCY; i++) id_sr[i] <= id_sr[i-1];
    end
  end

`ifdef ACT_ARB_STATS_EN
  logic [15:0] beats [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) beats[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && (grant == ID_W'(i)) && (beats[i] != 16'hFFFF)) beats[i] <= beats[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats[g*16 +: 16] = beats[g];
  end
`endif
endmodule
